// File: rtl/control_compuerta_pkg.sv
// -----------------------------------------------------------------------------
// control_compuerta_pkg
// Shared constants for the gate controller and its bench: FSM state encodings,
// default access/idle codes, attempt limit, PIN-state timeout and a saturating
// increment helper for the wrong-attempt counter.
// -----------------------------------------------------------------------------
package control_compuerta_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_ESPERA  = 3'd0,
        ST_PIN     = 3'd1,
        ST_ABIERTO = 3'd2,
        ST_ALARMA  = 3'd3,
        ST_BLOQUEO = 3'd4
    } estado_t;

    localparam logic [7:0] PIN_CORRECTO_DEF = 8'h08;
    localparam logic [7:0] PIN_ESPERA_DEF   = 8'h00;
    localparam int         MAX_INTENTOS_DEF = 3;
    localparam int         T_PIN_DEF        = 32;
    localparam int         INTENTOS_W       = 2;

    // Counter increment that sticks at the ceiling instead of wrapping.
    function automatic logic [INTENTOS_W-1:0] sat_inc(
        input logic [INTENTOS_W-1:0] valor,
        input logic [INTENTOS_W-1:0] tope
    );
        if (valor >= tope) begin
            return tope;
        end else begin
            return valor + 2'd1;
        end
    endfunction

endpackage

// File: rtl/control_compuerta_if.sv
// -----------------------------------------------------------------------------
// control_compuerta_if
// Sensor/keypad inputs and gate status outputs of the gate controller.
//   master : environment side (drives vehiculo, termino, pin; observes status)
//   slave  : controller side (samples inputs; drives cerrado, abierto, alarma,
//            bloqueo, intentos)
// -----------------------------------------------------------------------------
interface control_compuerta_if;
    import control_compuerta_pkg::*;

    logic                  vehiculo;
    logic                  termino;
    logic [7:0]            pin;
    logic                  cerrado;
    logic                  abierto;
    logic                  alarma;
    logic                  bloqueo;
    logic [INTENTOS_W-1:0] intentos;

    modport master (
        output vehiculo, termino, pin,
        input  cerrado, abierto, alarma, bloqueo, intentos
    );

    modport slave (
        input  vehiculo, termino, pin,
        output cerrado, abierto, alarma, bloqueo, intentos
    );

endinterface

// File: rtl/control_compuerta_detector_pin.sv
// -----------------------------------------------------------------------------
// detector_pin
// Keypad attempt detector. An attempt is the first cycle a non-idle code is
// seen after the keypad was idle; switching between two non-idle codes does
// not produce a new attempt.
//   clk, rst_n : clock, async active-low reset
//   pin        : keypad code
//   intento    : one-cycle pulse, a new code was presented this cycle
//   correcto   : one-cycle pulse, the new code equals PIN_CORRECTO
// -----------------------------------------------------------------------------
module detector_pin
    import control_compuerta_pkg::*;
#(
    parameter logic [7:0] PIN_CORRECTO = PIN_CORRECTO_DEF,
    parameter logic [7:0] PIN_ESPERA   = PIN_ESPERA_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pin,
    output logic       intento,
    output logic       correcto
);

    logic [7:0] pin_prev_r;

    // Previous-sample register; resets to idle so a code held through reset
    // release still counts as a fresh attempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_prev_r <= PIN_ESPERA;
        end else begin
            pin_prev_r <= pin;
        end
    end

    // Idle-to-code transition detection.
    always_comb begin
        intento  = (pin != PIN_ESPERA) && (pin_prev_r == PIN_ESPERA);
        correcto = intento && (pin == PIN_CORRECTO);
    end

endmodule

// File: rtl/control_compuerta.sv
// -----------------------------------------------------------------------------
// control_compuerta
// Parking gate controller (Moore FSM). A vehicle at the gate enables code
// entry; the correct code opens the gate, MAX_INTENTOS wrong codes raise the
// alarm, and a second vehicle at the gate while the first passes locks it.
// Alarm and lock are cleared only by the correct code.
//   clk, rst_n : clock, async active-low reset
//   bus        : control_compuerta_if.slave (vehiculo, termino, pin in;
//                cerrado, abierto, alarma, bloqueo, intentos out)
// -----------------------------------------------------------------------------
module control_compuerta
    import control_compuerta_pkg::*;
#(
    parameter logic [7:0] PIN_CORRECTO = PIN_CORRECTO_DEF,
    parameter logic [7:0] PIN_ESPERA   = PIN_ESPERA_DEF,
    parameter int         MAX_INTENTOS = MAX_INTENTOS_DEF,
    parameter int         T_PIN        = T_PIN_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    control_compuerta_if.slave  bus
);

    localparam logic [INTENTOS_W-1:0] MAX_L = INTENTOS_W'(MAX_INTENTOS);
    localparam int                    TW    = $clog2(T_PIN + 1);
    localparam logic [TW-1:0]         T_ULTIMO   = TW'(T_PIN - 1);
    localparam logic [TW-1:0]         TIMER_CERO = TW'(0);
    localparam logic [TW-1:0]         TIMER_UNO  = TW'(1);

    estado_t               estado_r;
    estado_t               estado_next_s;
    logic [INTENTOS_W-1:0] intentos_r;
    logic [INTENTOS_W-1:0] intentos_next_s;
    logic [INTENTOS_W-1:0] intentos_inc_s;
    logic [TW-1:0]         timer_r;
    logic [TW-1:0]         timer_next_s;
    logic                  intento_s;
    logic                  correcto_s;

    detector_pin #(
        .PIN_CORRECTO (PIN_CORRECTO),
        .PIN_ESPERA   (PIN_ESPERA)
    ) u_detector_pin (
        .clk      (clk),
        .rst_n    (rst_n),
        .pin      (bus.pin),
        .intento  (intento_s),
        .correcto (correcto_s)
    );

    // State, attempt counter and PIN-entry timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_r   <= ST_ESPERA;
            intentos_r <= 2'd0;
            timer_r    <= TIMER_CERO;
        end else begin
            estado_r   <= estado_next_s;
            intentos_r <= intentos_next_s;
            timer_r    <= timer_next_s;
        end
    end

    // Next-state, counter and timer logic.
    always_comb begin
        estado_next_s   = estado_r;
        intentos_next_s = intentos_r;
        timer_next_s    = TIMER_CERO;
        intentos_inc_s  = sat_inc(intentos_r, MAX_L);
        case (estado_r)
            ST_ESPERA: begin
                if (bus.vehiculo) begin
                    estado_next_s = ST_PIN;
                end else begin
                    estado_next_s = ST_ESPERA;
                end
            end
            ST_PIN: begin
                // Vehicle leaving wins over any code typed on the same edge.
                if (!bus.vehiculo) begin
                    estado_next_s   = ST_ESPERA;
                    intentos_next_s = 2'd0;
                end else if (intento_s) begin
                    if (correcto_s) begin
                        estado_next_s   = ST_ABIERTO;
                        intentos_next_s = 2'd0;
                    end else begin
                        intentos_next_s = intentos_inc_s;
                        if (intentos_inc_s == MAX_L) begin
                            estado_next_s = ST_ALARMA;
                        end else begin
                            estado_next_s = ST_PIN;
                        end
                    end
                end else if (timer_r == T_ULTIMO) begin
                    // T_PIN idle cycles since entry or last attempt.
                    estado_next_s   = ST_ESPERA;
                    intentos_next_s = 2'd0;
                end else begin
                    estado_next_s = ST_PIN;
                    timer_next_s  = timer_r + TIMER_UNO;
                end
            end
            ST_ABIERTO: begin
                if (bus.termino) begin
                    if (bus.vehiculo) begin
                        estado_next_s = ST_BLOQUEO;
                    end else begin
                        estado_next_s = ST_ESPERA;
                    end
                end else begin
                    estado_next_s = ST_ABIERTO;
                end
            end
            ST_ALARMA, ST_BLOQUEO: begin
                if (intento_s && correcto_s) begin
                    estado_next_s   = ST_ESPERA;
                    intentos_next_s = 2'd0;
                end else begin
                    estado_next_s = estado_r;
                end
            end
            default: begin
                estado_next_s   = ST_ESPERA;
                intentos_next_s = 2'd0;
            end
        endcase
    end

    // Moore output decode from the state register only.
    always_comb begin
        bus.abierto  = (estado_r == ST_ABIERTO);
        bus.cerrado  = (estado_r != ST_ABIERTO);
        bus.alarma   = (estado_r == ST_ALARMA) || (estado_r == ST_BLOQUEO);
        bus.bloqueo  = (estado_r == ST_BLOQUEO);
        bus.intentos = intentos_r;
    end

endmodule

// File: tb/tb_control_compuerta.sv
// -----------------------------------------------------------------------------
// tb_control_compuerta
// Self-checking bench: table of {vehiculo, termino, pin, expected status}
// applied one clock each, followed by hand-written timeout, held-code,
// priority and asynchronous-reset sequences.
// Status is compared as {cerrado, abierto, alarma, bloqueo, intentos[1:0]}.
// -----------------------------------------------------------------------------
module tb_control_compuerta;
    import control_compuerta_pkg::*;

    typedef struct {
        logic       veh;
        logic       term;
        logic [7:0] pin;
        logic [5:0] esp;
    } vec_t;

    localparam int N_VEC = 23;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t tabla [N_VEC];

    control_compuerta_if bus ();

    control_compuerta dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] st(input logic c, input logic a, input logic al,
                                      input logic b, input logic [1:0] i);
        return {c, a, al, b, i};
    endfunction

    function automatic logic [5:0] obs();
        return {bus.cerrado, bus.abierto, bus.alarma, bus.bloqueo, bus.intentos};
    endfunction

    task automatic check(input string nombre, input logic [5:0] esp);
        logic [5:0] got;
        got = obs();
        n_cmp++;
        if (got !== esp) begin
            n_err++;
            $display("FAIL %s: c/a/al/b/int got %b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
                     nombre, got[5], got[4], got[3], got[2], got[1:0],
                     esp[5], esp[4], esp[3], esp[2], esp[1:0]);
        end
    endtask

    // Drive inputs, take one rising edge, settle just after it.
    task automatic step(input logic veh, input logic term, input logic [7:0] p);
        bus.vehiculo = veh;
        bus.termino  = term;
        bus.pin      = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] cerr;
        logic [5:0] abie;
        n_cmp = 0;
        n_err = 0;
        cerr  = st(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        abie  = st(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

        // open then leave
        tabla[0]  = '{1'b1, 1'b0, 8'h00, cerr};
        tabla[1]  = '{1'b1, 1'b0, 8'h08, abie};
        tabla[2]  = '{1'b1, 1'b0, 8'h08, abie};
        tabla[3]  = '{1'b0, 1'b1, 8'h00, cerr};
        // three wrong codes -> alarm, wrong ignored, correct clears
        tabla[4]  = '{1'b1, 1'b0, 8'h00, cerr};
        tabla[5]  = '{1'b1, 1'b0, 8'h01, st(1'b1, 1'b0, 1'b0, 1'b0, 2'd1)};
        tabla[6]  = '{1'b1, 1'b0, 8'h00, st(1'b1, 1'b0, 1'b0, 1'b0, 2'd1)};
        tabla[7]  = '{1'b1, 1'b0, 8'h01, st(1'b1, 1'b0, 1'b0, 1'b0, 2'd2)};
        tabla[8]  = '{1'b1, 1'b0, 8'h00, st(1'b1, 1'b0, 1'b0, 1'b0, 2'd2)};
        tabla[9]  = '{1'b1, 1'b0, 8'h01, st(1'b1, 1'b0, 1'b1, 1'b0, 2'd3)};
        tabla[10] = '{1'b1, 1'b0, 8'h00, st(1'b1, 1'b0, 1'b1, 1'b0, 2'd3)};
        tabla[11] = '{1'b1, 1'b0, 8'h01, st(1'b1, 1'b0, 1'b1, 1'b0, 2'd3)};
        tabla[12] = '{1'b1, 1'b0, 8'h00, st(1'b1, 1'b0, 1'b1, 1'b0, 2'd3)};
        tabla[13] = '{1'b1, 1'b0, 8'h08, cerr};
        // open, stay open without timeout, tailgate -> lock, wrong ignored, correct clears
        tabla[14] = '{1'b1, 1'b0, 8'h00, cerr};
        tabla[15] = '{1'b1, 1'b0, 8'h08, abie};
        tabla[16] = '{1'b0, 1'b0, 8'h00, abie};
        tabla[17] = '{1'b1, 1'b1, 8'h00, st(1'b1, 1'b0, 1'b1, 1'b1, 2'd0)};
        tabla[18] = '{1'b0, 1'b0, 8'h05, st(1'b1, 1'b0, 1'b1, 1'b1, 2'd0)};
        tabla[19] = '{1'b0, 1'b0, 8'h00, st(1'b1, 1'b0, 1'b1, 1'b1, 2'd0)};
        tabla[20] = '{1'b0, 1'b0, 8'h08, cerr};
        tabla[21] = '{1'b0, 1'b0, 8'h00, cerr};
        // idle vehicle-absent: nothing happens
        tabla[22] = '{1'b0, 1'b1, 8'h00, cerr};

        // reset
        rst_n        = 1'b0;
        bus.vehiculo = 1'b0;
        bus.termino  = 1'b0;
        bus.pin      = 8'h00;
        #12;
        check("reset", cerr);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_idle", cerr);

        for (int k = 0; k < N_VEC; k++) begin
            step(tabla[k].veh, tabla[k].term, tabla[k].pin);
            check($sformatf("vec%0d", k), tabla[k].esp);
        end

        // timeout: T_PIN idle edges after the last attempt return to ESPERA
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        check("timeout_attempt", st(1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        repeat (T_PIN_DEF - 1) step(1'b1, 1'b0, 8'h00);
        check("timeout_before", st(1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        step(1'b1, 1'b0, 8'h00);
        check("timeout_expired", cerr);
        step(1'b0, 1'b0, 8'h00);

        // code changed without passing through idle is one wrong attempt
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        check("held_first", st(1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        step(1'b1, 1'b0, 8'h08);
        check("held_change", st(1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
        check("held_leave", cerr);

        // vehicle leaving beats a simultaneous attempt
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h01);
        check("drop_vs_wrong", cerr);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h08);
        check("drop_vs_correct", cerr);
        step(1'b0, 1'b0, 8'h08);
        check("drop_vs_correct_after", cerr);
        step(1'b0, 1'b0, 8'h00);

        // asynchronous reset while in ALARMA
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        check("alarm_reached", st(1'b1, 1'b0, 1'b1, 1'b0, 2'd3));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_alarm", cerr);
        bus.vehiculo = 1'b0;
        bus.pin      = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h08);
        check("after_reset_open", abie);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
